// File: rtl/qed_i_fifo.sv
// Instruction record/replay FIFO for QED: records original instructions, replays them in duplicate mode.
// Defining QED_I_FIFO_OVF_EN adds a sticky ovf output that flags dropped inserts.
module qed_i_fifo #(
  parameter int              IW       = 32,
  parameter int              DEPTH    = 16,
  parameter logic [6:0]      NOP_OPC  = 7'h7F,
  parameter logic [IW-1:0]   NOP_WORD = IW'('h7F)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exec_dup,
  input  logic                     if_stall,
  input  logic [IW-1:0]            in_instr,
  output logic [IW-1:0]            out_instr,
  output logic                     vld_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dup_done
`ifdef QED_I_FIFO_OVF_EN
  ,
  output logic                     ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [IW-1:0] mem [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          dup_done_q, dup_done_d;

  logic is_nop;
  logic ins;
  logic del;
  logic drop;

  assign is_nop = (in_instr[6:0] == NOP_OPC);
  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_C);

  // Direction is chosen solely by exec_dup, so ins and del are mutually exclusive.
  assign ins  = !rst && !exec_dup && !if_stall && !full && !is_nop;
  assign del  = !rst &&  exec_dup && !if_stall && !empty;
  assign drop = !rst && !exec_dup && !if_stall &&  full && !is_nop;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    dup_done_d = 1'b0;
    if (ins) begin
      tail_d  = tail_q + 1'b1;
      count_d = count_q + 1'b1;
    end
    if (del) begin
      head_d     = head_q + 1'b1;
      count_d    = count_q - 1'b1;
      dup_done_d = (count_q == (AW+1)'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      dup_done_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      dup_done_q <= dup_done_d;
    end
  end

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (ins) begin
      mem[tail_q] <= in_instr;
    end
  end

  always_comb begin
    out_instr = NOP_WORD;
    if (ins) begin
      out_instr = in_instr;
    end else if (del) begin
      out_instr = mem[head_q];
    end
  end

  assign vld_out  = ins | del;
  assign count    = count_q;
  assign dup_done = dup_done_q;

`ifdef QED_I_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q | drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
